alu_seq: RTL and testbench

Parametrised, handshaked ALU with iterative multiply/divide, the next generation of the team's 16-bit combinational ALU. It keeps the legacy AND/OR/ADD/SUB/SLT opcodes and semantics, adds shifts, XOR, signed compare, carry/overflow flags, a shift-add multiplier and a restoring divider. It sits in the execute stage between operand/register-read logic and writeback, and stalls the pipeline through valid/ready.

---
 rtl/alu_seq.sv | 260 ++++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle logic/arith/shift ops plus an
// iterative shift-add multiplier and a restoring divider. One request is in
// flight at a time. The result is held in DONE until the consumer takes it.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SRA   = 4'b1000;
  localparam logic [3:0] OP_SLTS  = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Result and flag registers presented to the consumer.
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  // Iteration state. opnd_q is the multiplicand for MUL and the divisor for
  // DIV; sel_q picks the high half (MULHU) or the remainder (REMU), both of
  // which have op[0] set.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sel_q, sel_d;

  // Single-cycle datapath signals.
  logic [WIDTH:0]     add_full;
  logic [WIDTH:0]     sub_full;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic               alu_ovf;

  // Iteration step signals.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH:0]     rem_shift;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_sub;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quo_step;

  // Request decode.
  logic               accept;
  logic               is_mul;
  logic               is_div;
  logic               div_zero;
  logic [WIDTH-1:0]   fast_res;

  assign accept   = in_valid && in_ready;
  assign is_mul   = (op == OP_MUL) || (op == OP_MULHU);
  assign is_div   = (op == OP_DIVU) || (op == OP_REMU);
  assign div_zero = is_div && (srcb == '0);

  // Single-cycle ALU evaluated on the live request operands.
  always_comb begin
    add_full  = {1'b0, srca} + {1'b0, srcb};
    sub_full  = {1'b0, srca} + {1'b0, ~srcb} + {{WIDTH{1'b0}}, 1'b1};
    shamt     = srcb[SHW-1:0];
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (op)
      OP_AND: alu_res = srca & srcb;
      OP_OR:  alu_res = srca | srcb;
      OP_XOR: alu_res = srca ^ srcb;
      OP_ADD: begin
        alu_res   = add_full[WIDTH-1:0];
        alu_carry = add_full[WIDTH];
        alu_ovf   = (srca[WIDTH-1] == srcb[WIDTH-1]) &&
                    (add_full[WIDTH-1] != srca[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = sub_full[WIDTH-1:0];
        alu_carry = sub_full[WIDTH];
        alu_ovf   = (srca[WIDTH-1] != srcb[WIDTH-1]) &&
                    (sub_full[WIDTH-1] != srca[WIDTH-1]);
      end
      OP_SLL:  alu_res = srca << shamt;
      OP_SRL:  alu_res = srca >> shamt;
      OP_SRA:  alu_res = WIDTH'($signed(srca) >>> shamt);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (srca < srcb)};
      OP_SLTS: alu_res = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      default: alu_res = '0;
    endcase
  end

  // One shift-add multiply step and one restoring-divide step.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    acc_step  = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                         : {1'b0, acc_q[2*WIDTH-1:1]};
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    rem_ge    = rem_shift >= {1'b0, opnd_q};
    // The true difference is below the divisor, so WIDTH bits are enough.
    rem_sub   = rem_shift[WIDTH-1:0] - opnd_q;
    rem_step  = rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
    quo_step  = {quo_q[WIDTH-2:0], rem_ge};
  end

  // Result for requests that finish straight away, including divide by zero.
  always_comb begin
    fast_res = alu_res;
    if (div_zero) begin
      fast_res = (op == OP_REMU) ? srca : '1;
    end
  end

  // Next-state, iteration and result-register logic.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    acc_d   = acc_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;

    case (state_q)
      S_MUL: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = S_DONE;
          cnt_d   = '0;
          res_d   = sel_q ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
          zero_d  = (res_d == '0);
          carry_d = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      S_DIV: begin
        quo_d = quo_step;
        rem_d = rem_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = S_DONE;
          cnt_d   = '0;
          res_d   = sel_q ? rem_step : quo_step;
          zero_d  = (res_d == '0);
          carry_d = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      S_DONE: begin
        if (out_ready && !in_valid) begin
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase

    // A new request can start from IDLE or straight out of a consumed DONE.
    if (accept) begin
      sel_d = op[0];
      cnt_d = '0;
      if (is_mul) begin
        state_d = S_MUL;
        acc_d   = {{WIDTH{1'b0}}, srcb};
        opnd_d  = srca;
      end else if (is_div && !div_zero) begin
        state_d = S_DIV;
        quo_d   = srca;
        rem_d   = '0;
        opnd_d  = srcb;
      end else begin
        state_d = S_DONE;
        res_d   = fast_res;
        zero_d  = (fast_res == '0);
        carry_d = alu_carry;
        ovf_d   = alu_ovf;
      end
    end
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      acc_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      acc_q   <= acc_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  // rst_n gates in_ready so nothing is taken while reset is held.
  assign in_ready  = rst_n && ((state_q == S_IDLE) ||
                               ((state_q == S_DONE) && out_ready));
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
  assign res       = res_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: a 16-bit and a 32-bit instance, table-driven
// vectors plus hand-written backpressure, streaming and reset sequences.
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        out_ready;
  logic [3:0]  op;

  logic        iv16, rdy16, ov16, z16, c16, v16, bz16;
  logic [15:0] a16, bb16, r16;
  logic        iv32, rdy32, ov32, z32, c32, v32, bz32;
  logic [31:0] a32, bb32, r32;

  alu_seq #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(rdy16), .op(op),
    .srca(a16), .srcb(bb16), .out_valid(ov16), .out_ready(out_ready),
    .res(r16), .zero(z16), .carry(c16), .ovf(v16), .busy(bz16)
  );

  alu_seq #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(rdy32), .op(op),
    .srca(a32), .srcb(bb32), .out_valid(ov32), .out_ready(out_ready),
    .res(r32), .zero(z32), .carry(c32), .ovf(v32), .busy(bz32)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  function automatic logic f_rdy(input bit w);
    return w ? rdy32 : rdy16;
  endfunction
  function automatic logic f_ov(input bit w);
    return w ? ov32 : ov16;
  endfunction
  function automatic logic f_busy(input bit w);
    return w ? bz32 : bz16;
  endfunction

  typedef struct {
    string       nm;
    bit          w;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
    logic        c;
    logic        v;
    int          lat;
  } vec_t;

  vec_t tv[$];

  function automatic void add_vec(input string nm, input bit w, input logic [3:0] o,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] r, input logic z, input logic c,
                                  input logic v, input int lat);
    tv.push_back('{nm, w, o, a, b, r, z, c, v, lat});
  endfunction

  // Issue one request, wait for its result, report result, flags, latency
  // (edges after accept) and the number of busy cycles seen.
  task automatic run(input bit w, input logic [3:0] o, input logic [31:0] a,
                     input logic [31:0] b, output logic [31:0] r, output logic z,
                     output logic c, output logic v, output int lat, output int nb);
    int t;
    @(negedge clk);
    out_ready = 1'b1;
    op = o;
    if (w) begin iv32 = 1'b1; a32 = a; bb32 = b; end
    else   begin iv16 = 1'b1; a16 = a[15:0]; bb16 = b[15:0]; end
    t = 0;
    while (!f_rdy(w) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("accept_timeout", 32'(t), 32'd0);
    @(negedge clk);
    iv16 = 1'b0;
    iv32 = 1'b0;
    lat = 1;
    nb  = 0;
    while (!f_ov(w) && lat < 100) begin
      if (f_busy(w)) nb++;
      @(negedge clk);
      lat++;
    end
    r = w ? r32 : {16'h0, r16};
    z = w ? z32 : z16;
    c = w ? c32 : c16;
    v = w ? v32 : v16;
  endtask

  initial begin
    logic [31:0] r, exp_r;
    logic        z, c, v;
    int          lat, nb;

    rst_n = 1'b0; out_ready = 1'b0; op = 4'h0;
    iv16 = 1'b0; a16 = '0; bb16 = '0;
    iv32 = 1'b0; a32 = '0; bb32 = '0;

    // Reset state, observed while rst_n is still low.
    #12;
    chk("rst_out_valid16", 32'(ov16), 32'd0);
    chk("rst_busy16",      32'(bz16), 32'd0);
    chk("rst_res16",       32'(r16),  32'd0);
    chk("rst_flags16",     {29'd0, z16, c16, v16}, 32'd0);
    chk("rst_in_ready16",  32'(rdy16), 32'd0);
    chk("rst_out_valid32", 32'(ov32), 32'd0);
    chk("rst_res32",       r32,       32'd0);
    chk("rst_in_ready32",  32'(rdy32), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready16", 32'(rdy16), 32'd1);
    chk("idle_in_ready32", 32'(rdy32), 32'd1);

    //       name           w     op     a             b             res           z c v lat
    add_vec("add_wrap",     1'b0, 4'h2,  32'hFFFF,     32'h0001,     32'h0000,     1,1,0, 1);
    add_vec("sub_ovf",      1'b0, 4'h6,  32'h8000,     32'h0001,     32'h7FFF,     0,1,1, 1);
    add_vec("sub_borrow",   1'b0, 4'h6,  32'h0005,     32'h0007,     32'hFFFE,     0,0,0, 1);
    add_vec("add_ovf",      1'b0, 4'h2,  32'h7FFF,     32'h0001,     32'h8000,     0,0,1, 1);
    add_vec("slt_u",        1'b0, 4'h7,  32'h8000,     32'h0001,     32'h0000,     1,0,0, 1);
    add_vec("slts",         1'b0, 4'h9,  32'h8000,     32'h0001,     32'h0001,     0,0,0, 1);
    add_vec("sra",          1'b0, 4'h8,  32'h8000,     32'h0013,     32'hF000,     0,0,0, 1);
    add_vec("sll",          1'b0, 4'h4,  32'h0001,     32'h0014,     32'h0010,     0,0,0, 1);
    add_vec("srl",          1'b0, 4'h5,  32'h8000,     32'h000F,     32'h0001,     0,0,0, 1);
    add_vec("and",          1'b0, 4'h0,  32'hF0F0,     32'h3C3C,     32'h3030,     0,0,0, 1);
    add_vec("or",           1'b0, 4'h1,  32'hF0F0,     32'h0F0F,     32'hFFFF,     0,0,0, 1);
    add_vec("xor",          1'b0, 4'h3,  32'hAAAA,     32'hAAAA,     32'h0000,     1,0,0, 1);
    add_vec("op_e",         1'b0, 4'hE,  32'hFFFF,     32'hFFFF,     32'h0000,     1,0,0, 1);
    add_vec("mul16",        1'b0, 4'hA,  32'h1234,     32'h0100,     32'h3400,     0,0,0, 17);
    add_vec("mulhu16",      1'b0, 4'hB,  32'hFFFF,     32'hFFFF,     32'hFFFE,     0,0,0, 17);
    add_vec("divu32",       1'b1, 4'hC,  32'd100,      32'd7,        32'd14,       0,0,0, 33);
    add_vec("remu32",       1'b1, 4'hD,  32'd100,      32'd7,        32'd2,        0,0,0, 33);
    add_vec("divu_zero",    1'b1, 4'hC,  32'h12345678, 32'h0,        32'hFFFFFFFF, 0,0,0, 1);
    add_vec("remu_zero",    1'b1, 4'hD,  32'd5,        32'h0,        32'd5,        0,0,0, 1);
    add_vec("divu_small",   1'b1, 4'hC,  32'd5,        32'd7,        32'd0,        1,0,0, 33);
    add_vec("divu_by1",     1'b1, 4'hC,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 0,0,0, 33);
    add_vec("mul32_lo",     1'b1, 4'hA,  32'h00010000, 32'h00010000, 32'h0,        1,0,0, 33);
    add_vec("mulhu32",      1'b1, 4'hB,  32'h00010000, 32'h00010000, 32'h1,        0,0,0, 33);

    foreach (tv[i]) begin
      run(tv[i].w, tv[i].op, tv[i].a, tv[i].b, r, z, c, v, lat, nb);
      $display("vec %-10s op=%h a=%h b=%h -> res=%h z=%0d c=%0d v=%0d lat=%0d busy=%0d",
               tv[i].nm, tv[i].op, tv[i].a, tv[i].b, r, z, c, v, lat, nb);
      chk({tv[i].nm, "_res"},   r,         tv[i].r);
      chk({tv[i].nm, "_zero"},  32'(z),    32'(tv[i].z));
      chk({tv[i].nm, "_carry"}, 32'(c),    32'(tv[i].c));
      chk({tv[i].nm, "_ovf"},   32'(v),    32'(tv[i].v));
      chk({tv[i].nm, "_lat"},   32'(lat),  32'(tv[i].lat));
      chk({tv[i].nm, "_busy"},  32'(nb),   32'(tv[i].lat - 1));
    end

    // Backpressure: result and flags must hold while the consumer stalls.
    @(negedge clk);
    out_ready = 1'b0;
    iv16 = 1'b1; op = 4'h2; a16 = 16'h7FFF; bb16 = 16'h0001;
    @(negedge clk);
    iv16 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      $display("stall %0d: valid=%0d res=%h ovf=%0d carry=%0d in_ready=%0d",
               k, ov16, r16, v16, c16, rdy16);
      chk("stall_valid",    32'(ov16),  32'd1);
      chk("stall_res",      32'(r16),   32'h8000);
      chk("stall_flags",    {30'd0, c16, v16}, 32'd1);
      chk("stall_in_ready", 32'(rdy16), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_idle", 32'(ov16), 32'd0);

    // Ten single-cycle ops back to back: one result per cycle, in order.
    exp_r = '0;
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) begin
        $display("stream %0d: valid=%0d res=%h expect=%h", i - 1, ov16, r16, exp_r[15:0]);
        chk("stream_valid", 32'(ov16), 32'd1);
        chk("stream_res",   32'(r16),  exp_r);
      end
      if (i < 10) begin
        iv16 = 1'b1;
        if (i % 2 == 0) begin
          op = 4'h2; a16 = 16'(i); bb16 = 16'h0100; exp_r = 32'h100 + 32'(i);
        end else begin
          op = 4'h6; a16 = 16'h0100; bb16 = 16'(i); exp_r = 32'h100 - 32'(i);
        end
      end else begin
        iv16 = 1'b0;
      end
      @(negedge clk);
    end

    // Reset in the middle of a multiply aborts it with no result.
    iv16 = 1'b1; op = 4'hA; a16 = 16'h1234; bb16 = 16'h0100;
    @(negedge clk);
    iv16 = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_mul_busy", 32'(bz16), 32'd1);
    rst_n = 1'b0;
    #1;
    $display("reset mid-mul: valid=%0d busy=%0d res=%h", ov16, bz16, r16);
    chk("rst_mid_valid", 32'(ov16), 32'd0);
    chk("rst_mid_busy",  32'(bz16), 32'd0);
    chk("rst_mid_res",   32'(r16),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_no_stale", 32'(ov16), 32'd0);
    chk("post_rst_busy",     32'(bz16), 32'd0);
    run(1'b0, 4'h2, 32'd2, 32'd3, r, z, c, v, lat, nb);
    $display("post-reset add 2+3 -> res=%h lat=%0d", r, lat);
    chk("post_rst_add_res", r, 32'd5);
    chk("post_rst_add_lat", 32'(lat), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
